// File: rtl/microwave_pkg.sv
// Shared types and constants for the keypad receiver: receiver state enum,
// BCD limits, preset width and a count-to-state helper.
package microwave_pkg;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      ENTRY  = 2'd1,
      FULL   = 2'd2,
      LOCKED = 2'd3
   } rx_state_t;

   localparam logic [3:0] BCD_MAX       = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
   localparam logic [1:0] PRESET_DIGITS = 2'd3;

   // Entry state implied by a digit count when entry is not locked.
   function automatic rx_state_t state_for_count(input logic [1:0] cnt);
      if (cnt == 2'd0)
         return EMPTY;
      else if (cnt == PRESET_DIGITS)
         return FULL;
      else
         return ENTRY;
   endfunction

endpackage

// File: rtl/keypad_receiver_if.sv
// Encoder/timer-facing bundle of the keypad receiver. The master modport is
// the environment (encoder + timer); the slave modport is the receiver.
interface keypad_receiver_if;
   logic [3:0] number;
   logic       loadn;
   logic       pgt;
   logic       enable;
   logic       take;
   logic [3:0] preset_sec_ones;
   logic [3:0] preset_sec_tens;
   logic [3:0] preset_mins;
   logic [1:0] digit_count;
   logic       preset_valid;
   logic       entry_error;

   modport master (
      output number, loadn, pgt, enable, take,
      input  preset_sec_ones, preset_sec_tens, preset_mins,
             digit_count, preset_valid, entry_error
   );

   modport slave (
      input  number, loadn, pgt, enable, take,
      output preset_sec_ones, preset_sec_tens, preset_mins,
             digit_count, preset_valid, entry_error
   );
endinterface

// File: rtl/strobe_edge.sv
// Rising-edge detector for the encoder load strobe, qualified by loadn.
// The history register resets high so a pgt held across reset is not an edge.
module strobe_edge (
   input  logic clock,
   input  logic clearn,
   input  logic pgt_i,
   input  logic loadn_i,
   output logic strobe_o
);

   logic pgt_q;

   always_ff @(posedge clock) begin
      if (!clearn)
         pgt_q <= 1'b1;
      else
         pgt_q <= pgt_i;
   end

   assign strobe_o = pgt_i & ~pgt_q & ~loadn_i;

endmodule

// File: rtl/keypad_receiver.sv
// Keypad digit receiver: shifts strobed BCD digits into a mins:tens:ones preset
// with valid/take handshake and mag_on lockout. Optional KEYPAD_RANGE_CHECK_EN.
//
// state  | meaning
// EMPTY  | no digits entered
// ENTRY  | one or two digits entered
// FULL   | three digits entered, further strobes flag an error
// LOCKED | enable (mag_on) high, entry frozen
import microwave_pkg::*;

module keypad_receiver (
   input  logic              clock,
   input  logic              clearn,
   keypad_receiver_if.slave  bus
);

   rx_state_t  state_q, state_d, state_eff;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] mins_q, mins_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic       err_q, err_d;
   logic       strobe;
   logic       valid;
   logic       take_ok;
   logic       range_bad;

   strobe_edge u_strobe_edge (
      .clock    (clock),
      .clearn   (clearn),
      .pgt_i    (bus.pgt),
      .loadn_i  (bus.loadn),
      .strobe_o (strobe)
   );

`ifdef KEYPAD_RANGE_CHECK_EN
   assign range_bad = (bus.number > BCD_MAX);
   assign valid     = (cnt_q != 2'd0) & ~bus.enable & (tens_q <= SEC_TENS_MAX);
`else
   assign range_bad = 1'b0;
   assign valid     = (cnt_q != 2'd0) & ~bus.enable;
`endif

   assign take_ok = bus.take & valid;

   // On the cycle enable drops, behave according to the held count.
   assign state_eff = (state_q == LOCKED) ? state_for_count(cnt_q) : state_q;

   always_ff @(posedge clock) begin
      if (!clearn)
         state_q <= EMPTY;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_for_count(cnt_d);
      if (bus.enable)
         state_d = LOCKED;
   end

   always_comb begin
      cnt_d  = cnt_q;
      mins_d = mins_q;
      tens_d = tens_q;
      ones_d = ones_q;
      err_d  = 1'b0;
      if (take_ok) begin
         cnt_d  = 2'd0;
         mins_d = 4'd0;
         tens_d = 4'd0;
         ones_d = 4'd0;
      end else if (strobe && !bus.enable) begin
         if (state_eff == FULL || range_bad) begin
            err_d = 1'b1;
         end else begin
            mins_d = tens_q;
            tens_d = ones_q;
            ones_d = bus.number;
            cnt_d  = cnt_q + 2'd1;
`ifdef KEYPAD_RANGE_CHECK_EN
            err_d  = (ones_q > SEC_TENS_MAX);
`endif
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!clearn) begin
         cnt_q  <= 2'd0;
         mins_q <= 4'd0;
         tens_q <= 4'd0;
         ones_q <= 4'd0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         mins_q <= mins_d;
         tens_q <= tens_d;
         ones_q <= ones_d;
         err_q  <= err_d;
      end
   end

   assign bus.preset_mins     = mins_q;
   assign bus.preset_sec_tens = tens_q;
   assign bus.preset_sec_ones = ones_q;
   assign bus.digit_count     = cnt_q;
   assign bus.preset_valid    = valid;
   assign bus.entry_error     = err_q;

endmodule
